fp_mul_norm_round: RTL and testbench

- Downstream stage of the 16x16 Wallace-tree significand multiplier in the floating-point multiplier datapath.
- Consumes the raw 33-bit significand product plus both operands' signs, biased exponents and special-case flags.
- Normalizes, rounds to nearest-even, handles exponent overflow/underflow, and packs an IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_mul_pkg.sv | 25 ++
 rtl/fp_round_pack.sv | 60 ++++++
 rtl/fp_mul_norm_round.sv | 117 +++++++++++
 tb/tb_fp_mul_norm_round.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants and stage-1 payload for the FP multiplier back end
package fp_mul_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int PROD_W   = 33;
    localparam int MANT_W   = 24;
    localparam int E_W      = 10;

    // Normalized beat carried from stage 1 to stage 2; e is two's complement
    typedef struct packed {
        logic              sign;
        logic [E_W-1:0]    e;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
        logic              zero;
        logic              inf;
        logic              nan;
        logic              bad;
    } s1_t;

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even, exception priority and IEEE-754 packing
module fp_round_pack import fp_mul_pkg::*; #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  s1_t                       beat_i,
    output logic [EXP_W+FRAC_W:0]     result_o,
    output logic                      ovf_o,
    output logic                      unf_o,
    output logic                      inexact_o
);

    logic                  rnd;
    logic [MANT_W:0]       m;
    logic signed [E_W-1:0] e_fin;
    logic [FRAC_W-1:0]     frac;
    logic                  unused_hidden;

    // The hidden bit is implied by the packed format and never stored
    assign unused_hidden = m[MANT_W-1];

    // Round, renormalize on carry-out, then apply exceptions in priority order
    always_comb begin
        rnd   = beat_i.guard & (beat_i.sticky | beat_i.mant[0]);
        m     = {1'b0, beat_i.mant} + {{MANT_W{1'b0}}, rnd};
        e_fin = $signed(beat_i.e) + (m[MANT_W] ? 10'sd1 : 10'sd0);
        frac  = m[MANT_W] ? '0 : m[FRAC_W-1:0];

        result_o  = {beat_i.sign, e_fin[EXP_W-1:0], frac};
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        inexact_o = beat_i.guard | beat_i.sticky;

        if (beat_i.nan || (beat_i.inf && beat_i.zero)) begin
            result_o  = QNAN;
            inexact_o = 1'b0;
        end else if (beat_i.inf) begin
            result_o  = {beat_i.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            inexact_o = 1'b0;
        end else if (beat_i.zero) begin
            result_o  = {beat_i.sign, {(EXP_W+FRAC_W){1'b0}}};
            inexact_o = 1'b0;
        end else if (beat_i.bad) begin
            // Product below 1.0 cannot come from two normalized operands
            result_o  = {beat_i.sign, {(EXP_W+FRAC_W){1'b0}}};
            unf_o     = 1'b1;
            inexact_o = 1'b0;
        end else if (e_fin >= $signed(10'(EXP_MAX))) begin
            result_o  = {beat_i.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_o     = 1'b1;
            inexact_o = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            // Flush to zero: subnormals are never produced
            result_o  = {beat_i.sign, {(EXP_W+FRAC_W){1'b0}}};
            unf_o     = 1'b1;
            inexact_o = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// rtl/fp_mul_norm_round.sv - two-stage normalize/round/pack stage after the significand multiplier
module fp_mul_norm_round #(
    parameter int BIAS   = 127,
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32:0]             prod,
    input  logic                    sign_a,
    input  logic                    sign_b,
    input  logic [EXP_W-1:0]        exp_a,
    input  logic [EXP_W-1:0]        exp_b,
    input  logic                    zero_in,
    input  logic                    inf_in,
    input  logic                    nan_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    ovf,
    output logic                    unf,
    output logic                    inexact
);
    import fp_mul_pkg::*;

    s1_t                   s1_q, s1_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [EXP_W+FRAC_W:0] result_q;
    logic                  ovf_q, unf_q, inexact_q;

    logic                  s2_free, s1_load, s2_load;
    logic [E_W-1:0]        e_sum;
    logic [EXP_W+FRAC_W:0] rp_result;
    logic                  rp_ovf, rp_unf, rp_inexact;
    logic                  unused_prod_msb;

    // Bit 32 of the 2.30 product can never be set by 1.15 operands
    assign unused_prod_msb = prod[32];

    // Handshake: stage 2 frees up when empty or draining; stage 1 when empty or moving on
    always_comb begin
        s2_free    = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_free;
        s1_load    = in_valid && in_ready;
        s2_load    = s1_valid_q && s2_free;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    end

    // Normalize the raw product to a 1.23 mantissa plus guard/sticky
    always_comb begin
        e_sum     = 10'({2'b00, exp_a}) + 10'({2'b00, exp_b}) - 10'(BIAS);
        s1_d      = '0;
        s1_d.sign = sign_a ^ sign_b;
        s1_d.zero = zero_in;
        s1_d.inf  = inf_in;
        s1_d.nan  = nan_in;
        s1_d.bad  = (prod[31:30] == 2'b00);
        if (prod[31]) begin
            s1_d.e      = e_sum + 10'd1;
            s1_d.mant   = prod[31:8];
            s1_d.guard  = prod[7];
            s1_d.sticky = |prod[6:0];
        end else begin
            s1_d.e      = e_sum;
            s1_d.mant   = prod[30:7];
            s1_d.guard  = prod[6];
            s1_d.sticky = |prod[5:0];
        end
    end

    fp_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .beat_i    (s1_q),
        .result_o  (rp_result),
        .ovf_o     (rp_ovf),
        .unf_o     (rp_unf),
        .inexact_o (rp_inexact)
    );

    // Pipeline registers; stage 2 holds its result while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_q <= s1_d;
            end
            if (s2_load) begin
                result_q  <= rp_result;
                ovf_q     <= rp_ovf;
                unf_q     <= rp_unf;
                inexact_q <= rp_inexact;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb/tb_fp_mul_norm_round.sv - self-checking bench for fp_mul_norm_round
module tb_fp_mul_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [32:0] prod;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic        zero_in, inf_in, nan_in;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        ovf, unf, inexact;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [32:0] p;
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic        z, i, n;
        logic [34:0] want;   // {ovf, unf, inexact, result}
    } vec_t;

    vec_t vt[$];
    vec_t bp[$];
    logic [34:0] sb_q[$];

    always #5 clk = ~clk;

    fp_mul_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .zero_in   (zero_in),
        .inf_in    (inf_in),
        .nan_in    (nan_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .inexact   (inexact)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued reasoning on the product with integer arithmetic
    function automatic logic [34:0] model(input logic [32:0] p, input logic sa, input logic sb,
                                          input logic [7:0] ea, input logic [7:0] eb,
                                          input logic z, input logic inf, input logic nan);
        int          e;
        int          sh;
        longint      mant, rem, half;
        logic [31:0] p32;
        logic        s;
        logic        inx;
        s   = sa ^ sb;
        e   = int'(ea) + int'(eb) - 127;
        p32 = p[31:0];
        if (nan || (inf && z)) return {3'b000, 32'h7FC0_0000};
        if (inf) return {3'b000, s, 8'hFF, 23'd0};
        if (z) return {3'b000, s, 31'd0};
        if (p32 < 32'h4000_0000) return {3'b010, s, 31'd0};
        if (p32 >= 32'h8000_0000) begin
            sh = 8;
            e  = e + 1;
        end else begin
            sh = 7;
        end
        mant = longint'(p32 >> sh);
        rem  = longint'(p32) % (longint'(1) << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = mant / 2;
            e    = e + 1;
        end
        inx = (rem != 0);
        if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b011, s, 31'd0};
        return {2'b00, inx, s, e[7:0], mant[22:0]};
    endfunction

    // Scoreboard: push on accept, check the head whenever a result is presented
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("result", {ovf, unf, inexact, result}, sb_q[0]);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(prod, sign_a, sign_b, exp_a, exp_b, zero_in, inf_in, nan_in));
        end
    end

    task automatic drive(input vec_t v);
        prod = v.p; sign_a = v.sa; sign_b = v.sb; exp_a = v.ea; exp_b = v.eb;
        zero_in = v.z; inf_in = v.i; nan_in = v.n;
    endtask

    task automatic send(input vec_t v);
        logic got;
        got = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", got, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        chk("drain", empty, 1);
    endtask

    function automatic vec_t mk(input logic [32:0] p, input logic sa, input logic sb,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic z, input logic i, input logic n,
                                input logic [34:0] want);
        vec_t v;
        v.p = p; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
        v.z = z; v.i = i; v.n = n; v.want = want;
        return v;
    endfunction

    initial begin
        int   acc, ov, idx, lat;
        logic a;

        vt.push_back(mk(33'h0_4000_0000, 0, 0, 127, 127, 0, 0, 0, {3'b000, 32'h3F80_0000}));
        vt.push_back(mk(33'h0_9000_0000, 0, 1, 127, 127, 0, 0, 0, {3'b000, 32'hC010_0000}));
        vt.push_back(mk(33'h0_4000_0040, 0, 0, 127, 127, 0, 0, 0, {3'b001, 32'h3F80_0000}));
        vt.push_back(mk(33'h0_4000_00C0, 0, 0, 127, 127, 0, 0, 0, {3'b001, 32'h3F80_0002}));
        vt.push_back(mk(33'h0_7FFF_FFC0, 0, 0, 127, 127, 0, 0, 0, {3'b001, 32'h4000_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0, 254, 254, 0, 0, 0, {3'b101, 32'h7F80_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0,  63,  63, 0, 0, 0, {3'b011, 32'h0000_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0, 127, 127, 0, 0, 1, {3'b000, 32'h7FC0_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0, 127, 127, 1, 1, 0, {3'b000, 32'h7FC0_0000}));
        vt.push_back(mk(33'h0_4000_0000, 1, 0, 127, 127, 0, 1, 0, {3'b000, 32'hFF80_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 1, 127, 127, 1, 0, 0, {3'b000, 32'h8000_0000}));
        vt.push_back(mk(33'h0_2000_0000, 1, 0, 127, 127, 0, 0, 0, {3'b010, 32'h8000_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0,  64,  63, 0, 0, 0, {3'b011, 32'h0000_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0,  64,  64, 0, 0, 0, {3'b000, 32'h0080_0000}));
        vt.push_back(mk(33'h0_4000_0000, 0, 0, 190, 191, 0, 0, 0, {3'b000, 32'h7F00_0000}));
        vt.push_back(mk(33'h0_8000_0000, 0, 0, 190, 191, 0, 0, 0, {3'b101, 32'h7F80_0000}));

        bp.push_back(mk(33'h0_5000_0000, 0, 0, 120, 130, 0, 0, 0, 35'd0));
        bp.push_back(mk(33'h0_6000_1234, 1, 0, 127, 100, 0, 0, 0, 35'd0));
        bp.push_back(mk(33'h0_A5A5_A5A5, 0, 1, 140, 110, 0, 0, 0, 35'd0));
        bp.push_back(mk(33'h0_4000_0180, 1, 1, 127, 127, 0, 0, 0, 35'd0));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(vt[0]);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", {ovf, unf, inexact, result}, 35'd0);

        foreach (vt[k])
            chk($sformatf("model_%0d", k),
                model(vt[k].p, vt[k].sa, vt[k].sb, vt[k].ea, vt[k].eb, vt[k].z, vt[k].i, vt[k].n),
                vt[k].want);

        @(posedge clk); #1;
        send(vt[0]);
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", lat, 2);
        drain();

        @(posedge clk); #1;
        foreach (vt[k]) send(vt[k]);
        drain();

        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0; acc = 0;
        drive(bp[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a = in_ready;
            if (a) acc++;
            @(posedge clk); #1;
            if (a) begin
                idx++;
                drive(bp[idx]);
            end
        end
        chk("bp_accepted", acc, 2);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        ov = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) ov++;
            a = in_valid && in_ready;
            @(posedge clk); #1;
            if (a) begin
                idx++;
                if (idx < 4) drive(bp[idx]);
                else in_valid = 1'b0;
            end
        end
        chk("bp_stream", ov, 4);
        chk("bp_all_accepted", idx, 4);
        in_valid = 1'b0;
        drain();

        @(posedge clk); #1;
        out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        @(negedge clk);
        chk("rst_full", {out_valid, in_ready}, 2'b10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_async_out_valid", out_valid, 0);
        #10 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
